// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Function : PC holder and single-outstanding instruction fetch feeding a
//            small registered FIFO drained into decode over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        imem_ihit,
    input  logic [31:0] imem_load,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH_CNT = (c_PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_FETCH   = 2'd1;
    localparam logic [1:0] c_DISCARD = 2'd2;
    localparam logic [1:0] c_HALTED  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        r_stale_addr;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [31:0]        r_mem_instr [FIFO_DEPTH];
    logic [31:0]        r_mem_pc    [FIFO_DEPTH];

    logic w_redir;
    logic w_pop;
    logic w_halt;
    logic w_push;
    logic w_flush;
    logic w_pop_eff;

    // Once halted, nothing but reset is allowed to disturb the unit.
    assign w_redir   = redirect && (r_state != c_HALTED);
    assign w_pop     = instr_valid && instr_ready;
    assign w_halt    = halt && w_pop && !w_redir;
    assign w_flush   = w_redir || w_halt;
    assign w_push    = (r_state == c_FETCH) && imem_ren && imem_ihit && !w_flush;
    assign w_pop_eff = w_pop && !w_flush;

    assign imem_addr   = (r_state == c_DISCARD) ? r_stale_addr : r_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? r_mem_pc[r_rd_ptr]    : 32'h0;

    always_comb begin
        imem_ren = 1'b0;
        case (r_state)
            c_FETCH:   imem_ren = (r_count < c_DEPTH_CNT);
            c_DISCARD: imem_ren = 1'b1;
            default:   imem_ren = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_redir) begin
            // A read already on the bus must be allowed to finish before the
            // new target can be requested.
            w_state_nxt = (imem_ren && !imem_ihit) ? c_DISCARD : c_FETCH;
        end else if (w_halt) begin
            w_state_nxt = c_HALTED;
        end else begin
            case (r_state)
                c_IDLE:    w_state_nxt = c_FETCH;
                c_DISCARD: w_state_nxt = imem_ihit ? c_FETCH : c_DISCARD;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= c_IDLE;
            r_pc         <= RESET_PC;
            r_stale_addr <= RESET_PC;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_redir) begin
                r_pc         <= {redirect_pc[31:2], 2'b00};
                r_stale_addr <= imem_addr;
            end else if (w_push) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_flush) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop_eff) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop_eff})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_load;
            r_mem_pc[r_wr_ptr]    <= r_pc;
        end
    end

endmodule
`default_nettype wire
